// File: rtl/alu_addition.sv
// alu_addition: registered adder slice of the datapath ALU.
// Operands X/Y are captured with in_valid; the sum and the Carry/Sign/Zero/
// Parity/Overflow flags appear one clock later together with out_valid.
// Without in_valid the result registers hold and out_valid drops.

module alu_addition #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  output logic [WIDTH-1:0] Z,
  output logic             Carry,
  output logic             Sign,
  output logic             Zero,
  output logic             Parity,
  output logic             Overflow
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum;
  logic             sum_carry;
  logic             sum_sign;
  logic             sum_zero;
  logic             sum_parity;
  logic             sum_overflow;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] z_d, z_q;
  logic             carry_d, carry_q;
  logic             sign_d, sign_q;
  logic             zero_d, zero_q;
  logic             parity_d, parity_q;
  logic             overflow_d, overflow_q;

  // Combinational adder core and flag derivation from the WIDTH+1-bit sum.
  always_comb begin
    sum_full     = {1'b0, X} + {1'b0, Y};
    sum          = sum_full[WIDTH-1:0];
    sum_carry    = sum_full[WIDTH];
    sum_sign     = sum[MSB];
    sum_zero     = ~(|sum);
    sum_parity   = ~(^sum);
    sum_overflow = (X[MSB] & Y[MSB] & ~sum[MSB]) |
                   (~X[MSB] & ~Y[MSB] & sum[MSB]);
  end

  // Next-state: load a fresh result on in_valid, otherwise hold the last one.
  always_comb begin
    out_valid_d = in_valid;
    z_d         = z_q;
    carry_d     = carry_q;
    sign_d      = sign_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    overflow_d  = overflow_q;
    if (in_valid) begin
      z_d        = sum;
      carry_d    = sum_carry;
      sign_d     = sum_sign;
      zero_d     = sum_zero;
      parity_d   = sum_parity;
      overflow_d = sum_overflow;
    end
  end

  // Result registers; synchronous reset wins over in_valid and drops any result in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      carry_q     <= 1'b0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      carry_q     <= carry_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Z         = z_q;
  assign Carry     = carry_q;
  assign Sign      = sign_q;
  assign Zero      = zero_q;
  assign Parity    = parity_q;
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_alu_addition.sv
// Bench for alu_addition: directed vector table plus reset/streaming sequences.

module tb_alu_addition;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             out_valid;
  logic [WIDTH-1:0] Z;
  logic             Carry;
  logic             Sign;
  logic             Zero;
  logic             Parity;
  logic             Overflow;

  int n_checks;
  int n_fail;

  alu_addition #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .X        (X),
    .Y        (Y),
    .out_valid(out_valid),
    .Z        (Z),
    .Carry    (Carry),
    .Sign     (Sign),
    .Zero     (Zero),
    .Parity   (Parity),
    .Overflow (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags packed as {Carry, Sign, Zero, Parity, Overflow}.
  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [4:0]  flags;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [15:0] x, input logic [15:0] y, input logic v);
    X = x;
    Y = y;
    in_valid = v;
    tick();
  endtask

  task automatic check(input string name, input logic ev, input logic [15:0] ez,
                       input logic [4:0] ef);
    logic [21:0] act;
    logic [21:0] exp;
    act = {out_valid, Z, Carry, Sign, Zero, Parity, Overflow};
    exp = {ev, ez, ef};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got valid=%b Z=%h CSZPO=%b, expected valid=%b Z=%h CSZPO=%b",
               name, act[21], act[20:5], act[4:0], exp[21], exp[20:5], exp[4:0]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{16'h8fff, 16'h8000, 16'h0fff, 5'b10011};
    vecs[1] = '{16'hfffe, 16'h0002, 16'h0000, 5'b10110};
    vecs[2] = '{16'haaaa, 16'h5555, 16'hffff, 5'b01010};
    vecs[3] = '{16'h4000, 16'h4000, 16'h8000, 5'b01001};
    vecs[4] = '{16'h8000, 16'h8fff, 16'h0fff, 5'b10011};
    vecs[5] = '{16'h7fff, 16'h0001, 16'h8000, 5'b01001};
    vecs[6] = '{16'hffff, 16'hffff, 16'hfffe, 5'b11000};
    vecs[7] = '{16'h8000, 16'h8000, 16'h0000, 5'b10111};
    vecs[8] = '{16'h0000, 16'h0000, 16'h0000, 5'b00110};
    vecs[9] = '{16'h0001, 16'h0002, 16'h0003, 5'b00010};

    // Reset held two cycles with in_valid asserted: outputs stay cleared.
    rst = 1'b1;
    X = 16'h1234;
    Y = 16'h1111;
    in_valid = 1'b1;
    tick();
    check("reset_edge1", 1'b0, 16'h0000, 5'b00000);
    tick();
    check("reset_edge2", 1'b0, 16'h0000, 5'b00000);

    // First edge after reset release captures the pending operands.
    rst = 1'b0;
    tick();
    check("post_reset_first", 1'b1, 16'h2345, 5'b00010);

    // Table vectors back to back, one result per cycle.
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].x, vecs[i].y, 1'b1);
      check($sformatf("vec%0d", i), 1'b1, vecs[i].z, vecs[i].flags);
    end

    // Idle gap, then the four reference vectors streamed on consecutive cycles.
    apply(16'h0000, 16'h0000, 1'b0);
    check("idle_hold", 1'b0, 16'h0003, 5'b00010);
    for (int i = 0; i < 4; i++) begin
      apply(vecs[i].x, vecs[i].y, 1'b1);
      check($sformatf("stream%0d", i), 1'b1, vecs[i].z, vecs[i].flags);
    end

    // Drop in_valid: valid falls, result and flags hold at 8000; new operands ignored.
    apply(16'h1111, 16'h2222, 1'b0);
    check("drop_valid_hold", 1'b0, 16'h8000, 5'b01001);
    apply(16'h3333, 16'h4444, 1'b0);
    check("drop_valid_hold2", 1'b0, 16'h8000, 5'b01001);

    // Reset on the cycle after an in_valid, with in_valid still high: reset wins.
    apply(16'h0001, 16'h0001, 1'b1);
    check("pre_reset_result", 1'b1, 16'h0002, 5'b00000);
    rst = 1'b1;
    apply(16'hffff, 16'h0001, 1'b1);
    check("reset_midflight", 1'b0, 16'h0000, 5'b00000);
    rst = 1'b0;
    apply(16'h0000, 16'h0000, 1'b0);
    check("after_reset_idle", 1'b0, 16'h0000, 5'b00000);

    // Carry and overflow together, recovering after reset.
    apply(16'h8001, 16'h8001, 1'b1);
    check("carry_and_ovf", 1'b1, 16'h0002, 5'b10001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
